// File: rtl/mixcol_seq_pkg.sv
// Shared definitions for the MixColumns sequencer:
//   - host register word addresses
//   - FSM state encoding
//   - DoRow unit-select table (unit index -> u_addr[11:10])
//   - field widths for amounts, block count, gap latency and config address
package mixcol_seq_pkg;

  localparam int AMT_W      = 6;
  localparam int NUM_AMT    = 8;
  localparam int NBLK_W     = 16;
  localparam int LAT_W      = 8;
  localparam int CFG_ADDR_W = 10;

  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_STATUS   = 4'd1;
  localparam logic [3:0] REG_NBLK     = 4'd2;
  localparam logic [3:0] REG_LAT      = 4'd3;
  localparam logic [3:0] REG_AMT_LO   = 4'd4;
  localparam logic [3:0] REG_AMT_HI   = 4'd5;
  localparam logic [3:0] REG_CFG_ADDR = 4'd6;
  localparam logic [3:0] REG_CFG_DATA = 4'd7;
  localparam logic [3:0] REG_CYCLES   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  // Unit index 0..3 maps to select 2'b11, 2'b01, 2'b10, 2'b00; index 0 sits in the LSBs.
  localparam logic [7:0] UNIT_SEL_TABLE = {2'b00, 2'b10, 2'b01, 2'b11};

  function automatic logic [1:0] unit_sel(input logic [1:0] idx);
    return UNIT_SEL_TABLE[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/mixcol_seq_regs.sv
// Host register file and handshake for the MixColumns sequencer.
// A request is accepted the cycle h_valid is seen with h_ready low; h_ready and
// h_rdata are registered and valid for exactly one cycle after that.
// Ports:
//   clk, rst_ni               clock, async active-low reset
//   h_valid_i .. h_rdata_o    host bus (nonzero h_wstrb_i = write, whole word)
//   busy_i/done_i/aborted_i   status bits from the FSM
//   cycles_i                  busy-cycle counter value (0 when not built)
//   start_o/abort_o           one-cycle pulses decoded from CTRL writes
//   cfg_en_o                  CTRL bit2 from the latest CTRL write
//   nblk_o/lat_o/amt_o        programmed run count, gap, DoRow amounts
//   cfg_addr_o/cfg_data_o     unit-local config address and data
module mixcol_seq_regs
  import mixcol_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             rst_ni,
  input  logic                             h_valid_i,
  input  logic [3:0]                       h_addr_i,
  input  logic [DATA_W/8-1:0]              h_wstrb_i,
  input  logic [DATA_W-1:0]                h_wdata_i,
  output logic                             h_ready_o,
  output logic [DATA_W-1:0]                h_rdata_o,
  input  logic                             busy_i,
  input  logic                             done_i,
  input  logic                             aborted_i,
  input  logic [31:0]                      cycles_i,
  output logic                             start_o,
  output logic                             abort_o,
  output logic                             cfg_en_o,
  output logic [NBLK_W-1:0]                nblk_o,
  output logic [LAT_W-1:0]                 lat_o,
  output logic [NUM_AMT-1:0][AMT_W-1:0]    amt_o,
  output logic [CFG_ADDR_W-1:0]            cfg_addr_o,
  output logic [DATA_W-1:0]                cfg_data_o
);

  logic                          ready_q;
  logic [DATA_W-1:0]             rdata_q;
  logic                          start_q, abort_q, cfg_en_q;
  logic [NBLK_W-1:0]             nblk_q;
  logic [LAT_W-1:0]              lat_q;
  logic [NUM_AMT-1:0][AMT_W-1:0] amt_q;
  logic [CFG_ADDR_W-1:0]         cfg_addr_q;
  logic [DATA_W-1:0]             cfg_data_q;

  logic              accept, wr, rd, ctrl_wr, prog_wr;
  logic [DATA_W-1:0] rd_mux;

  // Holding h_ready low for the cycle after an ack keeps a held request from being taken twice.
  assign accept  = h_valid_i && !ready_q;
  assign wr      = accept && (|h_wstrb_i);
  assign rd      = accept && !(|h_wstrb_i);
  assign ctrl_wr = wr && (h_addr_i == REG_CTRL);
  // Programming registers are frozen while a sequence runs.
  assign prog_wr = wr && !busy_i;

  always_comb begin
    // NOTE: assign a default before the case so every path drives rd_mux and no latch is inferred.
    rd_mux = '0;
    case (h_addr_i)
      REG_STATUS:   rd_mux = DATA_W'({aborted_i, done_i, busy_i});
      REG_NBLK:     rd_mux = DATA_W'(nblk_q);
      REG_LAT:      rd_mux = DATA_W'(lat_q);
      REG_AMT_LO:   rd_mux = DATA_W'({2'b00, amt_q[3], 2'b00, amt_q[2],
                                      2'b00, amt_q[1], 2'b00, amt_q[0]});
      REG_AMT_HI:   rd_mux = DATA_W'({2'b00, amt_q[7], 2'b00, amt_q[6],
                                      2'b00, amt_q[5], 2'b00, amt_q[4]});
      REG_CFG_ADDR: rd_mux = DATA_W'(cfg_addr_q);
      REG_CFG_DATA: rd_mux = cfg_data_q;
      REG_CYCLES:   rd_mux = DATA_W'(cycles_i);
      default:      rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      cfg_en_q   <= 1'b0;
      nblk_q     <= '0;
      lat_q      <= '0;
      amt_q      <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      ready_q <= accept;
      rdata_q <= rd ? rd_mux : '0;
      start_q <= ctrl_wr && h_wdata_i[0];
      abort_q <= ctrl_wr && h_wdata_i[1];
      if (ctrl_wr) cfg_en_q <= h_wdata_i[2];
      if (prog_wr) begin
        case (h_addr_i)
          REG_NBLK:     nblk_q     <= h_wdata_i[NBLK_W-1:0];
          REG_LAT:      lat_q      <= h_wdata_i[LAT_W-1:0];
          REG_AMT_LO:   for (int i = 0; i < 4; i++) amt_q[i]   <= h_wdata_i[i*8 +: AMT_W];
          REG_AMT_HI:   for (int i = 0; i < 4; i++) amt_q[i+4] <= h_wdata_i[i*8 +: AMT_W];
          REG_CFG_ADDR: cfg_addr_q <= h_wdata_i[CFG_ADDR_W-1:0];
          REG_CFG_DATA: cfg_data_q <= h_wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign h_ready_o  = ready_q;
  assign h_rdata_o  = rdata_q;
  assign start_o    = start_q;
  assign abort_o    = abort_q;
  assign cfg_en_o   = cfg_en_q;
  assign nblk_o     = nblk_q;
  assign lat_o      = lat_q;
  assign amt_o      = amt_q;
  assign cfg_addr_o = cfg_addr_q;
  assign cfg_data_o = cfg_data_q;

endmodule

// File: rtl/mixcolumns_seq.sv
// Host-programmable sequencer for one MixColumns Versat unit.
// Holds the eight DoRow buffer amounts, optionally broadcasts one config write
// to the four DoRow units, then issues NBLK one-cycle run pulses spaced LAT+1 apart.
// Ports:
//   clk, rst                 clock, async active-low reset
//   h_*                      host register bus (registered one-cycle h_ready)
//   u_*                      unit config bus; request held until u_ready
//   run                      registered run pulse to MixColumns
//   amount0..amount7         DoRow buffer amounts, straight from the registers
// Build option: define MIXCOL_SEQ_PERF_EN to add the 32-bit busy-cycle counter
// behind CYCLES; otherwise CYCLES reads 0.
module mixcolumns_seq
  import mixcol_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                h_valid,
  input  logic [3:0]          h_addr,
  input  logic [DATA_W/8-1:0] h_wstrb,
  input  logic [DATA_W-1:0]   h_wdata,
  output logic                h_ready,
  output logic [DATA_W-1:0]   h_rdata,
  output logic                u_valid,
  output logic [ADDR_W-1:0]   u_addr,
  output logic [DATA_W/8-1:0] u_wstrb,
  output logic [DATA_W-1:0]   u_wdata,
  input  logic                u_ready,
  output logic                run,
  output logic [AMT_W-1:0]    amount0,
  output logic [AMT_W-1:0]    amount1,
  output logic [AMT_W-1:0]    amount2,
  output logic [AMT_W-1:0]    amount3,
  output logic [AMT_W-1:0]    amount4,
  output logic [AMT_W-1:0]    amount5,
  output logic [AMT_W-1:0]    amount6,
  output logic [AMT_W-1:0]    amount7
);

  logic                          start, abort, cfg_en;
  logic [NBLK_W-1:0]             nblk;
  logic [LAT_W-1:0]              lat;
  logic [NUM_AMT-1:0][AMT_W-1:0] amt;
  logic [CFG_ADDR_W-1:0]         cfg_addr;
  logic [DATA_W-1:0]             cfg_data;
  logic [31:0]                   cycles;

  seq_state_e        state_q, state_d;
  logic [NBLK_W-1:0] blk_q, blk_d;
  logic [LAT_W-1:0]  gap_q, gap_d;
  logic [1:0]        unit_q, unit_d;
  logic              abort_pend_q, abort_pend_d;
  logic              busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic              run_q, run_d;

  mixcol_seq_regs #(.DATA_W(DATA_W)) u_regs (
    .clk        (clk),
    .rst_ni     (rst),
    .h_valid_i  (h_valid),
    .h_addr_i   (h_addr),
    .h_wstrb_i  (h_wstrb),
    .h_wdata_i  (h_wdata),
    .h_ready_o  (h_ready),
    .h_rdata_o  (h_rdata),
    .busy_i     (busy_q),
    .done_i     (done_q),
    .aborted_i  (aborted_q),
    .cycles_i   (cycles),
    .start_o    (start),
    .abort_o    (abort),
    .cfg_en_o   (cfg_en),
    .nblk_o     (nblk),
    .lat_o      (lat),
    .amt_o      (amt),
    .cfg_addr_o (cfg_addr),
    .cfg_data_o (cfg_data)
  );

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    gap_d        = gap_q;
    unit_d       = unit_q;
    abort_pend_d = abort_pend_q;
    busy_d       = busy_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    run_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d       = 1'b0;
          aborted_d    = 1'b0;
          busy_d       = 1'b1;
          blk_d        = nblk;
          unit_d       = 2'd0;
          abort_pend_d = 1'b0;
          state_d      = cfg_en ? ST_CFG : ST_RUN;
        end
      end
      ST_CFG: begin
        // An abort here only takes effect once the current unit write has completed.
        if (abort) abort_pend_d = 1'b1;
        if (u_ready) begin
          unit_d = unit_q + 2'd1;
          if (abort || abort_pend_q) begin
            aborted_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end else if (unit_q == 2'd3) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (blk_q == '0) begin
          state_d = ST_DONE;
        end else begin
          run_d   = 1'b1;
          blk_d   = blk_q - NBLK_W'(1);
          gap_d   = lat;
          state_d = (lat == '0) ? ST_RUN : ST_GAP;
        end
      end
      ST_GAP: begin
        // LAT idle cycles here plus the RUN cycle give LAT+1 pulse spacing.
        if (abort) begin
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          gap_d = gap_q - LAT_W'(1);
          if (gap_q <= LAT_W'(1)) state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      blk_q        <= '0;
      gap_q        <= '0;
      unit_q       <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      gap_q        <= gap_d;
      unit_q       <= unit_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      run_q        <= run_d;
    end
  end

`ifdef MIXCOL_SEQ_PERF_EN
  logic [31:0] cycles_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      cycles_q <= '0;
    end else if (busy_q) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end
  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

  // Unit bus is decoded from registered state, so an async reset drops it at once.
  assign u_valid = (state_q == ST_CFG);
  assign u_addr  = u_valid ? ADDR_W'({unit_sel(unit_q), cfg_addr}) : '0;
  assign u_wdata = u_valid ? cfg_data : '0;
  assign u_wstrb = '1;
  assign run     = run_q;

  assign amount0 = amt[0];
  assign amount1 = amt[1];
  assign amount2 = amt[2];
  assign amount3 = amt[3];
  assign amount4 = amt[4];
  assign amount5 = amt[5];
  assign amount6 = amt[6];
  assign amount7 = amt[7];

endmodule
